// File: rtl/wb_conbus_rr_pkg.sv
// wb_conbus_rr_pkg: shared widths, FSM encoding and slave address map for the
// round-robin Wishbone shared bus.
package wb_conbus_rr_pkg;
    localparam int DW_DEF = 32;
    localparam int AW_DEF = 32;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ERR = 2'd2} state_t;
    localparam logic [3:0] SLV_RAM  = 4'h0;
    localparam logic [3:0] SLV_VRAM = 4'h1;
    localparam logic [3:0] SLV_MIO  = 4'h3;
    localparam logic [3:0] SLV_PS2  = 4'h4;
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/wb_conbus_rr_arbiter.sv
// wb_rr_arbiter: combinational round-robin pick; first requester at or above
// the pointer, wrapping back to master 0.
module wb_rr_arbiter
    import wb_conbus_rr_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    localparam int PW = ptr_w(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [PW-1:0]          ptr_i,
    output logic [NUM_MASTERS-1:0] gnt_o
);
    logic w_found;
    always_comb begin
        gnt_o = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++)
            for (int j = 0; j < NUM_MASTERS; j++)
                if (!w_found && req_i[j] && j == (int'(ptr_i) + i) % NUM_MASTERS) begin
                    gnt_o[j] = 1'b1;
                    w_found = 1'b1;
                end
    end
endmodule

// File: rtl/wb_conbus_rr.sv
// wb_conbus_rr: Wishbone shared bus with round-robin master arbitration,
// address-field slave decode, and bus errors for unmapped slaves and timeouts.
module wb_conbus_rr
    import wb_conbus_rr_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int NUM_SLAVES  = 8,
    parameter int DW          = DW_DEF,
    parameter int AW          = AW_DEF,
    parameter int SEL_LO      = 28,
    parameter int SEL_W       = 4,
    parameter int TO_CYCLES   = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    output logic [DW-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    output logic [DW-1:0]               s_dat_o,
    output logic [AW-1:0]               s_adr_o,
    output logic [DW/8-1:0]             s_sel_o,
    output logic                        s_we_o,
    output logic [NUM_SLAVES-1:0]       s_stb_o,
    input  logic [NUM_SLAVES*DW-1:0]    s_dat_i,
    input  logic [NUM_SLAVES-1:0]       s_ack_i,
    output logic [NUM_MASTERS-1:0]      grant_o,
    output logic [15:0]                 err_cnt_o
);
    localparam int PW = ptr_w(NUM_MASTERS);
    localparam int SW = DW / 8;

    state_t                 r_state, w_next;
    logic [NUM_MASTERS-1:0] r_gnt, w_win;
    logic [PW-1:0]          r_ptr, w_ptr_nxt;
    logic [SEL_W-1:0]       r_idx, w_dec;
    logic [15:0]            r_to, r_err_cnt;
    logic [AW-1:0]          w_gadr;
    logic [DW-1:0]          w_gdat, w_sdat;
    logic [SW-1:0]          w_gsel;
    logic [NUM_SLAVES-1:0]  w_sdec;
    logic                   w_gwe, w_gstb, w_sack, w_busy, w_to_hit;

    wb_rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_arb (
        .req_i(m_stb_i),
        .ptr_i(r_ptr),
        .gnt_o(w_win)
    );

    always_comb begin
        w_gadr = '0;
        w_gdat = '0;
        w_gsel = '0;
        w_gwe = 1'b0;
        w_gstb = 1'b0;
        w_dec = '0;
        w_ptr_nxt = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (r_gnt[k]) begin
                w_gadr = m_adr_i[k*AW +: AW];
                w_gdat = m_dat_i[k*DW +: DW];
                w_gsel = m_sel_i[k*SW +: SW];
                w_gwe = m_we_i[k];
                w_gstb = m_stb_i[k];
                w_ptr_nxt = (k == NUM_MASTERS - 1) ? '0 : PW'(k + 1);
            end
            if (w_win[k]) w_dec = m_adr_i[k*AW+SEL_LO +: SEL_W];
        end
    end

    // The slave index is latched at grant time, so the slave side never re-decodes.
    always_comb begin
        w_sdec = '0;
        w_sdat = '0;
        for (int s = 0; s < NUM_SLAVES; s++)
            if (int'(r_idx) == s) begin
                w_sdec[s] = 1'b1;
                w_sdat = s_dat_i[s*DW +: DW];
            end
    end

    assign w_busy   = (r_state == BUSY);
    assign w_sack   = |(s_ack_i & w_sdec);
    assign w_to_hit = (r_to == 16'(TO_CYCLES));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (|m_stb_i) w_next = (int'(w_dec) >= NUM_SLAVES) ? ERR : BUSY;
            BUSY: w_next = (w_sack || !w_gstb) ? IDLE : w_to_hit ? ERR : BUSY;
            default: w_next = IDLE;
        endcase
    end

    assign s_adr_o   = w_busy ? w_gadr : '0;
    assign s_dat_o   = w_busy ? w_gdat : '0;
    assign s_sel_o   = w_busy ? w_gsel : '0;
    assign s_we_o    = w_busy & w_gwe;
    assign s_stb_o   = (w_busy && w_gstb && !w_to_hit) ? w_sdec : '0;
    assign m_dat_o   = w_busy ? w_sdat : '0;
    assign m_ack_o   = (w_busy && w_sack) ? r_gnt : '0;
    assign m_err_o   = (r_state == ERR) ? r_gnt : '0;
    assign grant_o   = (r_state == IDLE) ? '0 : r_gnt;
    assign err_cnt_o = r_err_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_idx     <= '0;
            r_ptr     <= '0;
            r_to      <= '0;
            r_err_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && |m_stb_i) begin
                r_gnt <= w_win;
                r_idx <= w_dec;
            end
            if ((w_busy && w_next == IDLE) || r_state == ERR) r_ptr <= w_ptr_nxt;
            r_to <= (w_busy && w_next == BUSY) ? r_to + 16'd1 : '0;
            if (r_state == ERR && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_wb_conbus_rr.sv
// tb_wb_conbus_rr: directed checks of arbitration order, decode, bus errors,
// timeout and asynchronous reset of wb_conbus_rr (4 masters, 8 slaves, timeout 4).
module tb_wb_conbus_rr;
    import wb_conbus_rr_pkg::*;
    localparam int NM = 4;
    localparam int NS = 8;

    typedef struct {
        logic [NM-1:0] stb;
        logic [NM-1:0] gnt;
        logic [NS-1:0] sstb;
        logic [NM-1:0] ack;
    } row_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NM*32-1:0] m_dat, m_adr;
    logic [NM*4-1:0]  m_sel;
    logic [NM-1:0]    m_we, m_stb, m_ack, m_err, gnt;
    logic [31:0]      m_dat_o, s_dat_o, s_adr_o;
    logic [3:0]       s_sel_o;
    logic             s_we_o;
    logic [NS-1:0]    s_stb, s_ack, auto_mask, ack_raw;
    logic [NS*32-1:0] s_dat;
    logic [15:0]      err_cnt;
    int checks = 0;
    int errors = 0;
    row_t tbl[12];

    always #5 clk = ~clk;
    assign s_ack = (s_stb & auto_mask) | ack_raw;

    wb_conbus_rr #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .TO_CYCLES(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .m_dat_i(m_dat), .m_adr_i(m_adr), .m_sel_i(m_sel), .m_we_i(m_we), .m_stb_i(m_stb),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack), .m_err_o(m_err),
        .s_dat_o(s_dat_o), .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_stb_o(s_stb), .s_dat_i(s_dat), .s_ack_i(s_ack),
        .grant_o(gnt), .err_cnt_o(err_cnt)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic chk_bus(input string n, input logic [NM-1:0] g, input logic [NS-1:0] ss,
                           input logic [NM-1:0] a, input logic [NM-1:0] e);
        chk({n, " grant"}, 32'(gnt), 32'(g));
        chk({n, " s_stb"}, 32'(s_stb), 32'(ss));
        chk({n, " m_ack"}, 32'(m_ack), 32'(a));
        chk({n, " m_err"}, 32'(m_err), 32'(e));
    endtask

    task automatic set_adr(input int k, input logic [31:0] a);
        m_adr[k*32 +: 32] = a;
    endtask

    initial begin
        m_dat = '0; m_adr = '0; m_sel = '1; m_we = '0; m_stb = '0;
        auto_mask = '0; ack_raw = '0;
        for (int s = 0; s < NS; s++) s_dat[s*32 +: 32] = 32'hA000_0000 + 32'(s);

        #1;
        chk_bus("reset", '0, '0, '0, '0);
        chk("reset err_cnt", 32'(err_cnt), 32'd0);
        chk("reset m_dat_o", m_dat_o, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // round robin: masters 0,1,3 hold stb to VRAM, zero-wait slave
        for (int k = 0; k < NM; k++) set_adr(k, {SLV_VRAM, 28'h0} | 32'(k << 4));
        auto_mask = '1;
        for (int i = 0; i < 12; i += 2) begin
            logic [NM-1:0] g;
            g = (i % 6 == 0) ? 4'b0001 : (i % 6 == 2) ? 4'b0010 : 4'b1000;
            tbl[i]   = '{stb: 4'b1011, gnt: 4'b0000, sstb: 8'h00, ack: 4'b0000};
            tbl[i+1] = '{stb: 4'b1011, gnt: g, sstb: 8'h02, ack: g};
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk) m_stb = tbl[i].stb;
            #1 chk_bus($sformatf("rr row %0d", i), tbl[i].gnt, tbl[i].sstb, tbl[i].ack, '0);
        end
        @(negedge clk) m_stb = '0;
        #1 chk_bus("rr drain", '0, '0, '0, '0);

        // single write from master 0 to slave 2
        @(negedge clk);
        set_adr(0, 32'h2000_0010);
        m_dat[31:0] = 32'hDEAD_BEEF;
        m_we = 4'b0001;
        m_stb = 4'b0001;
        #1 chk_bus("wr idle", '0, '0, '0, '0);
        @(negedge clk) #1;
        chk_bus("wr busy", 4'b0001, 8'b0000_0100, 4'b0001, '0);
        chk("wr s_dat_o", s_dat_o, 32'hDEAD_BEEF);
        chk("wr s_adr_o", s_adr_o, 32'h2000_0010);
        chk("wr s_we_o", 32'(s_we_o), 32'd1);
        chk("wr m_dat_o", m_dat_o, 32'hA000_0002);
        @(negedge clk) m_stb = '0; m_we = '0;
        #1 chk_bus("wr done", '0, '0, '0, '0);

        // unmapped slave 15 from master 2
        @(negedge clk);
        set_adr(2, 32'hF000_0000);
        m_stb = 4'b0100;
        #1 chk_bus("unmap idle", '0, '0, '0, '0);
        @(negedge clk) #1 chk_bus("unmap err", 4'b0100, '0, '0, 4'b0100);
        @(negedge clk) m_stb = '0;
        #1 chk_bus("unmap done", '0, '0, '0, '0);
        chk("unmap err_cnt", 32'(err_cnt), 32'd1);

        // timeout on slave 3; ack from unselected slave 5 must be ignored
        auto_mask = '0;
        ack_raw = 8'b0010_0000;
        @(negedge clk);
        set_adr(0, {SLV_MIO, 28'h0});
        m_stb = 4'b0001;
        #1 chk_bus("to idle", '0, '0, '0, '0);
        for (int i = 0; i < 4; i++)
            @(negedge clk) #1 chk_bus($sformatf("to wait %0d", i), 4'b0001, 8'b0000_1000, '0, '0);
        @(negedge clk) #1 chk_bus("to mature", 4'b0001, '0, '0, '0);
        @(negedge clk) #1 chk_bus("to err", 4'b0001, '0, '0, 4'b0001);
        @(negedge clk) m_stb = '0; ack_raw = '0;
        #1 chk_bus("to done", '0, '0, '0, '0);
        chk("to err_cnt", 32'(err_cnt), 32'd2);

        // abort: master 0 drops stb while waiting
        @(negedge clk) m_stb = 4'b0001;
        #1 chk_bus("abort idle", '0, '0, '0, '0);
        @(negedge clk) #1 chk_bus("abort busy", 4'b0001, 8'b0000_1000, '0, '0);
        @(negedge clk) m_stb = '0;
        #1 chk_bus("abort drop", 4'b0001, '0, '0, '0);
        @(negedge clk) #1 chk_bus("abort done", '0, '0, '0, '0);
        chk("abort err_cnt", 32'(err_cnt), 32'd2);

        // ack arrives in the same cycle the timeout matures
        @(negedge clk);
        set_adr(1, {SLV_MIO, 28'h0});
        m_stb = 4'b0010;
        #1 chk_bus("race idle", '0, '0, '0, '0);
        for (int i = 0; i < 4; i++)
            @(negedge clk) #1 chk_bus($sformatf("race wait %0d", i), 4'b0010, 8'b0000_1000, '0, '0);
        @(negedge clk) ack_raw = 8'b0000_1000;
        #1 chk_bus("race ack", 4'b0010, '0, 4'b0010, '0);
        @(negedge clk) ack_raw = '0; m_stb = '0;
        #1 chk_bus("race done", '0, '0, '0, '0);
        chk("race err_cnt", 32'(err_cnt), 32'd2);

        // reset during a wait-stated transfer from master 2 (pointer is 2 here)
        @(negedge clk);
        set_adr(2, {SLV_MIO, 28'h0});
        m_stb = 4'b0100;
        #1 chk_bus("rst idle", '0, '0, '0, '0);
        @(negedge clk) #1 chk_bus("rst busy0", 4'b0100, 8'b0000_1000, '0, '0);
        @(negedge clk) #1 chk_bus("rst busy1", 4'b0100, 8'b0000_1000, '0, '0);
        rst_n = 1'b0;
        #1;
        chk_bus("rst async", '0, '0, '0, '0);
        chk("rst err_cnt", 32'(err_cnt), 32'd0);
        chk("rst s_adr_o", s_adr_o, 32'd0);
        m_stb = '0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        set_adr(1, {SLV_VRAM, 28'h0});
        set_adr(3, {SLV_VRAM, 28'h0});
        auto_mask = '1;
        m_stb = 4'b1010;
        #1 chk_bus("post idle", '0, '0, '0, '0);
        @(negedge clk) #1 chk_bus("post grant", 4'b0010, 8'b0000_0010, 4'b0010, '0);
        @(negedge clk) m_stb = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_conbus_rr.md
Name: wb_conbus_rr

Overview:
- Parametrised Wishbone shared-bus interconnect; successor to the fixed 2-master/8-slave conbus.
- Sits between the CPU, future DMA/VGA masters and memory-mapped slaves: data RAM, VRAM, MIO_BUS, PS2_IO.
- Adds fair round-robin arbitration across NUM_MASTERS, an address decode over a configurable bit field, and a bus-error response for unmapped addresses and for slaves that never acknowledge.

Parameters:
- NUM_MASTERS, 4: number of master ports (1..8).
- NUM_SLAVES, 8: number of slave ports (1..16).
- DW, 32: data width.
- AW, 32: address width.
- SEL_LO, 28: LSB of the slave-select field in the address.
- SEL_W, 4: width of the slave-select field. Slave index = adr[SEL_LO+SEL_W-1:SEL_LO].
- TO_CYCLES, 255: bus-busy cycles allowed before timeout error (1..65535).

Ports:
- clk_i  in  1  bus clock.
- rst_n_i  in  1  asynchronous active-low reset.
- m_dat_i  in  NUM_MASTERS*DW  write data; master k uses slice k.
- m_adr_i  in  NUM_MASTERS*AW  address per master.
- m_sel_i  in  NUM_MASTERS*(DW/8)  byte selects per master.
- m_we_i  in  NUM_MASTERS  write enable per master.
- m_stb_i  in  NUM_MASTERS  request strobe per master.
- m_dat_o  out  DW  read data; granted slave's dat_i, broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  acknowledge, one-hot to the granted master.
- m_err_o  out  NUM_MASTERS  bus error, one-hot to the granted master.
- s_dat_o  out  DW  write data to slaves, broadcast.
- s_adr_o  out  AW  address to slaves, broadcast.
- s_sel_o  out  DW/8  byte selects, broadcast.
- s_we_o  out  1  write enable, broadcast.
- s_stb_o  out  NUM_SLAVES  strobe, one-hot to the decoded slave.
- s_dat_i  in  NUM_SLAVES*DW  read data per slave.
- s_ack_i  in  NUM_SLAVES  acknowledge per slave.
- grant_o  out  NUM_MASTERS  current one-hot grant (debug / 7-seg test display).
- err_cnt_o  out  16  saturating count of bus errors.

Behaviour:

Reset (rst_n_i low, asynchronous):
- State = IDLE, grant = 0, round-robin pointer = 0, timeout counter = 0, err_cnt_o = 0.
- All stb/ack/err outputs 0.
- Reset asserted mid-transfer aborts the transfer with no ack or err.

States:
- IDLE:
  - No outputs active; s_stb_o = 0.
  - If any m_stb_i is high, latch the winner into grant: the first requesting master scanning upward from pointer with wrap (pointer, pointer+1, ..., NUM_MASTERS-1, 0, ...).
  - Latch slave index from the winner's address. Go to BUSY, or to ERR if index >= NUM_SLAVES.
- BUSY:
  - Mux the granted master's adr/dat/sel/we onto the s_* outputs.
  - s_stb_o[idx] = m_stb_i[granted]. Slave index is held from the IDLE latch; it is not re-decoded.
  - m_ack_o[granted] = s_ack_i[idx] combinationally, in the same cycle.
  - On ack: next state IDLE, pointer = granted+1 (wraps), timeout counter cleared.
  - If the granted master drops stb before ack (abort): return to IDLE with no ack/err, pointer advances.
  - Timeout counter increments each BUSY cycle. When it equals TO_CYCLES with no ack: go to ERR and drop s_stb_o in that same cycle.
- ERR:
  - m_err_o[granted] = 1 for exactly one cycle; s_stb_o = 0.
  - err_cnt_o increments, saturating at 16'hFFFF.
  - Next state IDLE; pointer advances.

Timing rules:
- Minimum transfer is 2 cycles: request seen in IDLE at cycle n, slave strobed at n+1, ack at n+1 for a zero-wait slave.
- One idle turnaround cycle between back-to-back grants.
- An ack arriving in the same cycle the timeout matures wins: the transfer completes normally with no err.
- s_ack_i from non-selected slaves is ignored.
- A master that keeps stb high after ack re-enters arbitration in IDLE like any other requester, so no master can starve another.

Other:
- m_dat_o = s_dat_i slice idx while BUSY, 0 otherwise.
- grant_o = latched grant while BUSY/ERR, 0 in IDLE.
- Master with NUM_MASTERS = 1 degenerates to a pass-through plus decode, error and timeout.

Decomposition:
- Shared defines header (extends wb_conbus_defines.v):
  - data/address width defaults;
  - state encodings IDLE = 2'd0, BUSY = 2'd1, ERR = 2'd2;
  - slave-map constants: slave index to base-address nibble (RAM = 0, VRAM = 1, MIO = 3, PS2 = 4, ...).
- Sub-module wb_rr_arbiter:
  - parametrised by NUM_MASTERS;
  - inputs: request vector, pointer; output: one-hot winner; purely combinational priority rotate.
  - The top keeps the FSM, decode, muxes and counters.

Test Plan:
- Single master 0 writes 32'hDEADBEEF to 32'h2000_0010; slave 2 acks immediately -> s_stb_o = 8'b0000_0100 at cycle 1, s_dat_o = DEADBEEF, m_ack_o = 4'b0001 at cycle 1, back to IDLE at cycle 2.
- Masters 0, 1, 3 hold stb continuously to slave 1; slave acks each strobe -> grant sequence 0, 1, 3, 0, 1, 3; no master is skipped.
- Master 2 reads 32'hF000_0000 with NUM_SLAVES = 8 (index 15, unmapped) -> no s_stb_o; m_err_o = 4'b0100 for one cycle; err_cnt_o = 1.
- Slave 3 never acks, TO_CYCLES = 4 -> m_err_o asserted after 4 BUSY cycles, s_stb_o drops in that cycle, err_cnt_o increments.
- Ack and timeout in the same cycle -> m_ack_o asserted, m_err_o stays 0, err_cnt_o unchanged.
- rst_n_i pulsed low during BUSY with 3 wait states -> all outputs 0 immediately; the next request from master 1 after release is granted with the pointer at 0.
